// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - EX/MEM inputs, dcache request/response and writeback bundle for mem_stage_ctrl
interface mem_stage_ctrl_if #(
    parameter int WORD_W = 32,
    parameter int RSEL_W = 5
);
    logic              ex_valid;
    logic [WORD_W-1:0] ex_porto;
    logic [WORD_W-1:0] ex_portb;
    logic [WORD_W-1:0] ex_extimm;
    logic [WORD_W-1:0] ex_npc;
    logic [RSEL_W-1:0] ex_wsel;
    logic              ex_regwen;
    logic [1:0]        ex_regsrc;
    logic              ex_ren;
    logic              ex_wen;
    logic              ex_halt;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              mem_stall;
    logic              wb_wen;
    logic [RSEL_W-1:0] wb_wsel;
    logic [WORD_W-1:0] wb_wdat;
    logic              wb_halt;
`ifdef MEM_PERF_EN
    logic [31:0]       perf_retired;
    logic [31:0]       perf_memstall;
    logic [31:0]       perf_memops;
`endif

    modport slave (
        input  ex_valid, ex_porto, ex_portb, ex_extimm, ex_npc, ex_wsel,
               ex_regwen, ex_regsrc, ex_ren, ex_wen, ex_halt, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_wen, wb_wsel, wb_wdat, wb_halt
`ifdef MEM_PERF_EN
        , output perf_retired, perf_memstall, perf_memops
`endif
    );

    modport master (
        output ex_valid, ex_porto, ex_portb, ex_extimm, ex_npc, ex_wsel,
               ex_regwen, ex_regsrc, ex_ren, ex_wen, ex_halt, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_wen, wb_wsel, wb_wdat, wb_halt
`ifdef MEM_PERF_EN
        , input perf_retired, perf_memstall, perf_memops
`endif
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MIPS MEM stage with dcache handshake, stall, MEM/WB latch and sticky halt; MEM_PERF_EN adds perf counters
module mem_stage_ctrl #(
    parameter int WORD_W = 32,
    parameter int RSEL_W = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    mem_stage_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALTED} state_t;

    state_t            state_q, state_d;
    logic              wb_wen_q, wb_wen_d;
    logic [RSEL_W-1:0] wb_wsel_q, wb_wsel_d;
    logic [WORD_W-1:0] wb_wdat_q, wb_wdat_d;
    logic              wb_halt_q, wb_halt_d;

    logic              memop;
    logic              halted;
    logic              req_ren;
    logic              req_wen;
    logic              stall;
    logic              retire_halt;
    logic [WORD_W-1:0] sel_wdat;
    logic              unused_extimm_hi;

    assign memop            = bus.ex_valid & (bus.ex_ren | bus.ex_wen);
    assign halted           = (state_q == S_HALTED);
    assign unused_extimm_hi = ^bus.ex_extimm[WORD_W-1:16];

    // Request/stall generation is purely combinational so a zero-wait hit never stalls.
    always_comb begin
        state_d     = state_q;
        req_ren     = 1'b0;
        req_wen     = 1'b0;
        stall       = 1'b0;
        retire_halt = 1'b0;
        if (nRST) begin
            case (state_q)
                S_IDLE, S_WAIT: begin
                    req_ren     = memop & bus.ex_ren;
                    req_wen     = memop & bus.ex_wen & ~bus.ex_ren;
                    stall       = memop & ~bus.dhit;
                    retire_halt = bus.ex_valid & bus.ex_halt & ~stall;
                    if (retire_halt)
                        state_d = S_HALTED;
                    else if (stall)
                        state_d = S_WAIT;
                    else
                        state_d = S_IDLE;
                end
                S_HALTED: stall = 1'b1;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_wdat = bus.ex_porto;
        case (bus.ex_regsrc)
            2'b00:   sel_wdat = bus.ex_porto;
            2'b01:   sel_wdat = bus.dmemload;
            2'b10:   sel_wdat = bus.ex_npc;
            default: sel_wdat = {bus.ex_extimm[15:0], {(WORD_W-16){1'b0}}};
        endcase
    end

    // A stalled cycle loads a bubble so the held instruction writes back exactly once.
    always_comb begin
        wb_wen_d  = wb_wen_q;
        wb_wsel_d = wb_wsel_q;
        wb_wdat_d = wb_wdat_q;
        wb_halt_d = wb_halt_q;
        if (halted) begin
            wb_wen_d = 1'b0;
        end else if (stall) begin
            wb_wen_d  = 1'b0;
            wb_wsel_d = '0;
            wb_wdat_d = '0;
        end else begin
            wb_wen_d  = bus.ex_valid & bus.ex_regwen & (bus.ex_wsel != '0);
            wb_wsel_d = bus.ex_wsel;
            wb_wdat_d = sel_wdat;
            if (retire_halt)
                wb_halt_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            wb_wen_q  <= 1'b0;
            wb_wsel_q <= '0;
            wb_wdat_q <= '0;
            wb_halt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_wen_q  <= wb_wen_d;
            wb_wsel_q <= wb_wsel_d;
            wb_wdat_q <= wb_wdat_d;
            wb_halt_q <= wb_halt_d;
        end
    end

    assign bus.dmemREN   = req_ren;
    assign bus.dmemWEN   = req_wen;
    assign bus.dmemaddr  = bus.ex_porto;
    assign bus.dmemstore = bus.ex_portb;
    assign bus.mem_stall = stall;
    assign bus.wb_wen    = wb_wen_q;
    assign bus.wb_wsel   = wb_wsel_q;
    assign bus.wb_wdat   = wb_wdat_q;
    assign bus.wb_halt   = wb_halt_q;

`ifdef MEM_PERF_EN
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_memstall_q, perf_memstall_d;
    logic [31:0] perf_memops_q, perf_memops_d;
    logic        ev_retired;
    logic        ev_memstall;
    logic        ev_memops;

    assign ev_retired  = ~halted & ~stall & bus.ex_valid &
                         ((bus.ex_regwen & (bus.ex_wsel != '0)) |
                          (bus.ex_wen & ~bus.ex_ren) | bus.ex_halt);
    assign ev_memstall = ~halted & stall;
    assign ev_memops   = ~halted & bus.dhit & (req_ren | req_wen);

    always_comb begin
        perf_retired_d  = perf_retired_q;
        perf_memstall_d = perf_memstall_q;
        perf_memops_d   = perf_memops_q;
        if (ev_retired && perf_retired_q != 32'hFFFF_FFFF)
            perf_retired_d = perf_retired_q + 32'd1;
        if (ev_memstall && perf_memstall_q != 32'hFFFF_FFFF)
            perf_memstall_d = perf_memstall_q + 32'd1;
        if (ev_memops && perf_memops_q != 32'hFFFF_FFFF)
            perf_memops_d = perf_memops_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            perf_retired_q  <= '0;
            perf_memstall_q <= '0;
            perf_memops_q   <= '0;
        end else begin
            perf_retired_q  <= perf_retired_d;
            perf_memstall_q <= perf_memstall_d;
            perf_memops_q   <= perf_memops_d;
        end
    end

    assign bus.perf_retired  = perf_retired_q;
    assign bus.perf_memstall = perf_memstall_q;
    assign bus.perf_memops   = perf_memops_q;
`endif
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - table-driven and randomized self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    logic CLK;
    logic nRST;
    int   n_vec;
    int   n_err;

    mem_stage_ctrl_if #(.WORD_W(32), .RSEL_W(5)) bus ();

    mem_stage_ctrl #(.WORD_W(32), .RSEL_W(5)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [31:0] porto;
        logic [31:0] portb;
        logic [31:0] extimm;
        logic [31:0] npc;
        logic [4:0]  wsel;
        logic        regwen;
        logic [1:0]  regsrc;
        logic        ren;
        logic        wen;
        logic        halt;
        logic        dhit;
        logic [31:0] load;
        logic        e_ren;
        logic        e_wen;
        logic        e_stall;
        logic        e_wbw;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdat;
        logic        e_halt;
    } vec_t;

    // Reference model state: what the writeback latch should hold and whether a halt has retired.
    logic        m_halted;
    logic        m_wbw;
    logic [4:0]  m_wsel;
    logic [31:0] m_wdat;

    function automatic vec_t mk(
        input logic rst_n, input logic valid, input logic [31:0] porto, input logic [31:0] portb,
        input logic [31:0] extimm, input logic [31:0] npc, input logic [4:0] wsel, input logic regwen,
        input logic [1:0] regsrc, input logic ren, input logic wen, input logic halt,
        input logic dhit, input logic [31:0] load,
        input logic e_ren, input logic e_wen, input logic e_stall,
        input logic e_wbw, input logic [4:0] e_wsel, input logic [31:0] e_wdat, input logic e_halt);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.porto = porto; v.portb = portb;
        v.extimm = extimm; v.npc = npc; v.wsel = wsel; v.regwen = regwen;
        v.regsrc = regsrc; v.ren = ren; v.wen = wen; v.halt = halt;
        v.dhit = dhit; v.load = load;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_stall = e_stall;
        v.e_wbw = e_wbw; v.e_wsel = e_wsel; v.e_wdat = e_wdat; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs driven just after the rising edge, combinational outputs sampled at the falling
    // edge, registered outputs sampled 1 time unit after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        nRST          = v.rst_n;
        bus.ex_valid  = v.valid;
        bus.ex_porto  = v.porto;
        bus.ex_portb  = v.portb;
        bus.ex_extimm = v.extimm;
        bus.ex_npc    = v.npc;
        bus.ex_wsel   = v.wsel;
        bus.ex_regwen = v.regwen;
        bus.ex_regsrc = v.regsrc;
        bus.ex_ren    = v.ren;
        bus.ex_wen    = v.wen;
        bus.ex_halt   = v.halt;
        bus.dhit      = v.dhit;
        bus.dmemload  = v.load;
        #4;
        chk({tag, " dmemREN"},   {31'd0, bus.dmemREN},   {31'd0, v.e_ren});
        chk({tag, " dmemWEN"},   {31'd0, bus.dmemWEN},   {31'd0, v.e_wen});
        chk({tag, " mem_stall"}, {31'd0, bus.mem_stall}, {31'd0, v.e_stall});
        chk({tag, " dmemaddr"},  bus.dmemaddr,  v.porto);
        chk({tag, " dmemstore"}, bus.dmemstore, v.portb);
        @(posedge CLK);
        #1;
        chk({tag, " wb_wen"},  {31'd0, bus.wb_wen},  {31'd0, v.e_wbw});
        chk({tag, " wb_wsel"}, {27'd0, bus.wb_wsel}, {27'd0, v.e_wsel});
        chk({tag, " wb_wdat"}, bus.wb_wdat, v.e_wdat);
        chk({tag, " wb_halt"}, {31'd0, bus.wb_halt}, {31'd0, v.e_halt});
    endtask

    // Behavioural model: fills in expectations for one cycle from the stage's rules and advances.
    task automatic predict(inout vec_t v);
        logic memop;
        logic [31:0] res;
        memop = v.valid && (v.ren || v.wen);
        case (v.regsrc)
            2'd0:    res = v.porto;
            2'd1:    res = v.load;
            2'd2:    res = v.npc;
            default: res = v.extimm << 16;
        endcase
        if (!v.rst_n) begin
            v.e_ren = 0; v.e_wen = 0; v.e_stall = 0;
            m_halted = 0; m_wbw = 0; m_wsel = 0; m_wdat = 0;
        end else if (m_halted) begin
            v.e_ren = 0; v.e_wen = 0; v.e_stall = 1;
            m_wbw = 0;
        end else begin
            v.e_ren   = memop && v.ren;
            v.e_wen   = memop && v.wen && !v.ren;
            v.e_stall = memop && !v.dhit;
            if (v.e_stall) begin
                m_wbw = 0; m_wsel = 0; m_wdat = 0;
            end else begin
                m_wbw  = v.valid && v.regwen && (v.wsel != 0);
                m_wsel = v.wsel;
                m_wdat = res;
                if (v.valid && v.halt) m_halted = 1;
            end
        end
        v.e_wbw = m_wbw; v.e_wsel = m_wsel; v.e_wdat = m_wdat; v.e_halt = m_halted;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;
        m_halted = 0; m_wbw = 0; m_wsel = 0; m_wdat = 0;
        nRST = 1'b0;
        bus.ex_valid = 0; bus.ex_porto = 0; bus.ex_portb = 0; bus.ex_extimm = 0;
        bus.ex_npc = 0; bus.ex_wsel = 0; bus.ex_regwen = 0; bus.ex_regsrc = 0;
        bus.ex_ren = 0; bus.ex_wen = 0; bus.ex_halt = 0; bus.dhit = 0; bus.dmemload = 0;

        //            rst v porto        portb          extimm   npc    ws rw rs rn wn h dh load          | rn wn st wbw ws wdat          hlt
        tbl.push_back(mk(0,0,0,          0,             0,       0,     0, 0,0, 0,0,0,0, 0,            0,0,0, 0,0, 0,            0));
        tbl.push_back(mk(0,1,32'h400,    0,             0,       0,     9, 1,1, 1,0,0,0, 0,            0,0,0, 0,0, 0,            0));
        tbl.push_back(mk(1,1,32'h1234,   0,             0,       0,     5, 1,0, 0,0,0,0, 0,            0,0,0, 1,5, 32'h1234,     0));
        tbl.push_back(mk(1,1,32'h100,    0,             0,       0,     8, 1,1, 1,0,0,0, 0,            1,0,1, 0,0, 0,            0));
        tbl.push_back(mk(1,1,32'h100,    0,             0,       0,     8, 1,1, 1,0,0,0, 0,            1,0,1, 0,0, 0,            0));
        tbl.push_back(mk(1,1,32'h100,    0,             0,       0,     8, 1,1, 1,0,0,1, 32'hDEADBEEF, 1,0,0, 1,8, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1,0,0,          0,             0,       0,     0, 0,0, 0,0,0,0, 0,            0,0,0, 0,0, 0,            0));
        tbl.push_back(mk(1,1,32'h200,    32'hCAFE0001,  0,       0,     0, 0,0, 0,1,0,1, 0,            0,1,0, 0,0, 32'h200,      0));
        tbl.push_back(mk(1,1,32'h300,    0,             0,       0,     0, 0,1, 1,1,0,1, 32'h55,       1,0,0, 0,0, 32'h55,       0));
        tbl.push_back(mk(1,1,0,          0,             32'hABCD,0,     0, 1,3, 0,0,0,0, 0,            0,0,0, 0,0, 32'hABCD0000, 0));
        tbl.push_back(mk(1,1,0,          0,             32'hABCD,0,     3, 1,3, 0,0,0,0, 0,            0,0,0, 1,3, 32'hABCD0000, 0));
        tbl.push_back(mk(1,1,0,          0,             0,       32'h44,4, 1,2, 0,0,0,0, 0,            0,0,0, 1,4, 32'h44,       0));
        tbl.push_back(mk(1,0,0,          0,             0,       0,     0, 0,0, 0,0,0,1, 32'h99,       0,0,0, 0,0, 0,            0));
        tbl.push_back(mk(1,0,32'h10,     0,             0,       0,     7, 1,0, 1,0,0,0, 0,            0,0,0, 0,7, 32'h10,       0));
        tbl.push_back(mk(1,1,32'h400,    0,             0,       0,     9, 1,1, 1,0,0,0, 0,            1,0,1, 0,0, 0,            0));
        tbl.push_back(mk(0,1,32'h400,    0,             0,       0,     9, 1,1, 1,0,0,0, 0,            0,0,0, 0,0, 0,            0));
        tbl.push_back(mk(1,0,0,          0,             0,       0,     0, 0,0, 0,0,0,0, 0,            0,0,0, 0,0, 0,            0));
        tbl.push_back(mk(1,1,32'h400,    0,             0,       0,     9, 1,1, 1,0,0,1, 32'h77,       1,0,0, 1,9, 32'h77,       0));
        tbl.push_back(mk(1,1,32'h500,    0,             0,       0,     0, 0,0, 1,0,1,0, 0,            1,0,1, 0,0, 0,            0));
        tbl.push_back(mk(1,1,32'h500,    0,             0,       0,     0, 0,0, 1,0,1,1, 32'h66,       1,0,0, 0,0, 32'h500,      1));
        tbl.push_back(mk(1,1,32'h600,    0,             0,       0,     8, 1,1, 1,0,0,1, 32'h88,       0,0,1, 0,0, 32'h500,      1));
        tbl.push_back(mk(1,0,0,          0,             0,       0,     0, 0,0, 0,0,0,0, 0,            0,0,1, 0,0, 32'h500,      1));
        tbl.push_back(mk(0,0,0,          0,             0,       0,     0, 0,0, 0,0,0,0, 0,            0,0,0, 0,0, 0,            0));
        tbl.push_back(mk(1,1,32'h1234,   0,             0,       0,     5, 1,0, 0,0,0,0, 0,            0,0,0, 1,5, 32'h1234,     0));

        @(posedge CLK);
        #1;
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Hand-written corner: a plain halt (no memory access) with a register write in the same slot.
        v = mk(1,1,32'h70,0,0,0,6,1,0,0,0,1,0,0, 0,0,0, 1,6,32'h70,1);
        apply(v, "halt_alu");
        v = mk(1,1,32'h80,0,0,0,6,1,0,0,0,0,0,0, 0,0,1, 0,6,32'h70,1);
        apply(v, "halt_hold");

        for (int i = 0; i < 800; i++) begin
            v = mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
            v.rst_n  = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            v.valid  = ($urandom_range(0, 3) != 0);
            v.porto  = $urandom;
            v.portb  = $urandom;
            v.extimm = $urandom;
            v.npc    = $urandom;
            v.wsel   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            v.regwen = $urandom_range(0, 1);
            v.regsrc = 2'($urandom);
            v.ren    = ($urandom_range(0, 2) == 0);
            v.wen    = ($urandom_range(0, 2) == 0);
            v.halt   = ($urandom_range(0, 59) == 0);
            v.dhit   = $urandom_range(0, 1);
            v.load   = $urandom;
            predict(v);
            apply(v, $sformatf("rnd[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
